// File: rtl/ctl_lap.sv
// ctl_lap -- stopwatch control FSM with a circular lap-snapshot buffer.
//
// Sequences the counter datapath through IDLE / RUN / SPLIT / PAUSE from the
// debounced trig and split buttons. Every split event while counting (RUN or
// SPLIT) captures count_in into a circular buffer which readout logic drains
// one entry per lap_rd pulse.
//
// Parameters:
//   CNT_W     width of one lap snapshot
//   DEPTH     number of lap entries (power of two, >= 2)
//   EDGE_DET  1: act on rising edges of trig/split; 0: act on every high cycle
//   OVERWRITE 1: capture into a full buffer replaces the oldest entry;
//             0: capture into a full buffer is dropped
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   trig, split     start/stop and split/lap/clear buttons (debounced)
//   count_in        running count, sampled on lap capture
//   lap_rd          pop request, one cycle per entry
//   init_regs       clear counter registers (IDLE)
//   count_enabled   counter runs (RUN, SPLIT)
//   display_hold    display frozen (SPLIT)
//   lap_data        last popped entry (registered)
//   lap_valid       buffer not empty
//   lap_full        buffer holds DEPTH entries
//   lap_count       number of stored entries
//   lap_ovf         sticky: a lap was dropped or overwritten since last clear
module ctl_lap #(
    parameter int CNT_W     = 16,
    parameter int DEPTH     = 8,
    parameter bit EDGE_DET  = 1'b1,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       trig,
    input  logic                       split,
    input  logic [CNT_W-1:0]           count_in,
    input  logic                       lap_rd,
    output logic                       init_regs,
    output logic                       count_enabled,
    output logic                       display_hold,
    output logic [CNT_W-1:0]           lap_data,
    output logic                       lap_valid,
    output logic                       lap_full,
    output logic [$clog2(DEPTH+1)-1:0] lap_count,
    output logic                       lap_ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_SPLIT = 2'b10,
        ST_PAUSE = 2'b11
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               trig_q_r;
    logic               split_q_r;
    logic               t_ev_s;
    logic               s_ev_s;
    logic               cap_s;
    logic               clr_s;
    logic               pop_s;
    logic               full_s;
    logic               drop_s;
    logic               ow_s;
    logic               wr_s;
    logic [CW-1:0]      cnt_r;
    logic [CW-1:0]      cnt_nxt_s;
    logic               ovf_r;
    logic               ovf_nxt_s;
    logic               valid_r;
    logic               full_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   lap_data_r;
    logic [CNT_W-1:0]   mem_r [DEPTH];
    logic               init_regs_r;
    logic               count_enabled_r;
    logic               display_hold_r;

    // Moore output decode: {init_regs, count_enabled, display_hold}.
    function automatic logic [2:0] decode_outputs(input state_t st);
        logic [2:0] res;
        case (st)
            ST_IDLE:  res = 3'b100;
            ST_RUN:   res = 3'b010;
            ST_SPLIT: res = 3'b011;
            ST_PAUSE: res = 3'b000;
            default:  res = 3'b100;
        endcase
        return res;
    endfunction

    // Button event detection (rising edge or raw level).
    always_comb begin
        if (EDGE_DET) begin
            t_ev_s = trig & ~trig_q_r;
            s_ev_s = split & ~split_q_r;
        end else begin
            t_ev_s = trig;
            s_ev_s = split;
        end
    end

    // Next-state logic; trig has priority, so a simultaneous split is lost.
    always_comb begin
        state_nxt_s = state_r;
        cap_s       = 1'b0;
        clr_s       = 1'b0;
        if (t_ev_s) begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_RUN;
                ST_RUN:   state_nxt_s = ST_PAUSE;
                ST_SPLIT: state_nxt_s = ST_PAUSE;
                ST_PAUSE: state_nxt_s = ST_RUN;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end else if (s_ev_s) begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_IDLE;
                ST_RUN: begin
                    state_nxt_s = ST_SPLIT;
                    cap_s       = 1'b1;
                end
                ST_SPLIT: begin
                    state_nxt_s = ST_RUN;
                    cap_s       = 1'b1;
                end
                ST_PAUSE: begin
                    state_nxt_s = ST_IDLE;
                    clr_s       = 1'b1;
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Buffer bookkeeping. A pop in the same cycle as a capture frees the slot
    // first, so a full buffer only overflows when no pop accompanies the write.
    always_comb begin
        full_s = (cnt_r == CW'(DEPTH));
        pop_s  = lap_rd & (cnt_r != {CW{1'b0}}) & ~clr_s;
        drop_s = cap_s & full_s & ~pop_s & (OVERWRITE == 1'b0);
        ow_s   = cap_s & full_s & ~pop_s & (OVERWRITE == 1'b1);
        wr_s   = cap_s & ~drop_s;
        if (clr_s) begin
            cnt_nxt_s = {CW{1'b0}};
            ovf_nxt_s = 1'b0;
        end else begin
            // An overwrite replaces an entry, so occupancy does not grow.
            cnt_nxt_s = cnt_r + CW'(wr_s & ~ow_s) - CW'(pop_s);
            ovf_nxt_s = ovf_r | drop_s | ow_s;
        end
    end

    // Control state, button history and registered Moore outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            trig_q_r        <= 1'b0;
            split_q_r       <= 1'b0;
            init_regs_r     <= 1'b1;
            count_enabled_r <= 1'b0;
            display_hold_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            trig_q_r  <= trig;
            split_q_r <= split;
            {init_regs_r, count_enabled_r, display_hold_r} <= decode_outputs(state_nxt_s);
        end
    end

    // Pointers, occupancy, flags and popped data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            cnt_r      <= {CW{1'b0}};
            ovf_r      <= 1'b0;
            valid_r    <= 1'b0;
            full_r     <= 1'b0;
            lap_data_r <= {CNT_W{1'b0}};
        end else begin
            if (clr_s) begin
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
            end else begin
                if (wr_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
                // Overwrite discards the oldest entry by moving the head too.
                if (pop_s | ow_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
            end
            if (pop_s) begin
                lap_data_r <= mem_r[rd_ptr_r];
            end else begin
                lap_data_r <= lap_data_r;
            end
            cnt_r   <= cnt_nxt_s;
            ovf_r   <= ovf_nxt_s;
            valid_r <= (cnt_nxt_s != {CW{1'b0}});
            full_r  <= (cnt_nxt_s == CW'(DEPTH));
        end
    end

    // Lap storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= count_in;
        end
    end

    assign init_regs     = init_regs_r;
    assign count_enabled = count_enabled_r;
    assign display_hold  = display_hold_r;
    assign lap_data      = lap_data_r;
    assign lap_valid     = valid_r;
    assign lap_full      = full_r;
    assign lap_count     = cnt_r;
    assign lap_ovf       = ovf_r;

endmodule

// File: tb/tb_ctl_lap.sv
// Testbench for ctl_lap. Three instances share one stimulus stream:
//   u0: EDGE_DET=1 OVERWRITE=0, u1: EDGE_DET=1 OVERWRITE=1, u2: EDGE_DET=0 OVERWRITE=0.
// A queue-style reference model (array with shift-on-pop) predicts every
// instance each cycle; a vector table and hand sequences check u0/u1/u2 corners.
module tb_ctl_lap;
    localparam int N = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_SPLIT = 2, M_PAUSE = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        trig, split, lap_rd;
    logic [15:0] count_in;
    logic        ir [N];
    logic        ce [N];
    logic        dh [N];
    logic        lv [N];
    logic        lf [N];
    logic        lo [N];
    logic [15:0] ld [N];
    logic [3:0]  lc [N];

    always #5 clk = ~clk;

    ctl_lap #(.CNT_W(16), .DEPTH(8), .EDGE_DET(1'b1), .OVERWRITE(1'b0)) u0 (
        .clk(clk), .reset(reset), .trig(trig), .split(split), .count_in(count_in),
        .lap_rd(lap_rd), .init_regs(ir[0]), .count_enabled(ce[0]), .display_hold(dh[0]),
        .lap_data(ld[0]), .lap_valid(lv[0]), .lap_full(lf[0]), .lap_count(lc[0]), .lap_ovf(lo[0]));
    ctl_lap #(.CNT_W(16), .DEPTH(8), .EDGE_DET(1'b1), .OVERWRITE(1'b1)) u1 (
        .clk(clk), .reset(reset), .trig(trig), .split(split), .count_in(count_in),
        .lap_rd(lap_rd), .init_regs(ir[1]), .count_enabled(ce[1]), .display_hold(dh[1]),
        .lap_data(ld[1]), .lap_valid(lv[1]), .lap_full(lf[1]), .lap_count(lc[1]), .lap_ovf(lo[1]));
    ctl_lap #(.CNT_W(16), .DEPTH(8), .EDGE_DET(1'b0), .OVERWRITE(1'b0)) u2 (
        .clk(clk), .reset(reset), .trig(trig), .split(split), .count_in(count_in),
        .lap_rd(lap_rd), .init_regs(ir[2]), .count_enabled(ce[2]), .display_hold(dh[2]),
        .lap_data(ld[2]), .lap_valid(lv[2]), .lap_full(lf[2]), .lap_count(lc[2]), .lap_ovf(lo[2]));

    // Reference model state
    int          m_st  [N];
    bit          m_pt  [N];
    bit          m_ps  [N];
    logic [15:0] m_q   [N][8];
    int          m_sz  [N];
    bit          m_ovf [N];
    logic [15:0] m_dat [N];

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        t;
        logic        s;
        logic [15:0] cin;
        logic        rd;
        logic        e_init;
        logic        e_ce;
        logic        e_dh;
        logic [3:0]  e_cnt;
        logic [15:0] e_data;
        logic        e_valid;
        logic        e_ovf;
    } vec_t;

    vec_t tbl [18];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = M_IDLE; m_pt[i] = 1'b0; m_ps[i] = 1'b0;
            m_sz[i] = 0; m_ovf[i] = 1'b0; m_dat[i] = 16'h0000;
        end
    endtask

    task automatic model_step(input int i, input bit t, input bit s,
                              input logic [15:0] c, input bit r);
        bit edg, ow, te, se, cap, clr;
        edg = (i != 2);
        ow  = (i == 1);
        te  = edg ? (t & ~m_pt[i]) : t;
        se  = edg ? (s & ~m_ps[i]) : s;
        m_pt[i] = t; m_ps[i] = s;
        cap = 1'b0; clr = 1'b0;
        if (te) begin
            if (m_st[i] == M_IDLE || m_st[i] == M_PAUSE) m_st[i] = M_RUN;
            else m_st[i] = M_PAUSE;
        end else if (se) begin
            if (m_st[i] == M_RUN) begin cap = 1'b1; m_st[i] = M_SPLIT; end
            else if (m_st[i] == M_SPLIT) begin cap = 1'b1; m_st[i] = M_RUN; end
            else if (m_st[i] == M_PAUSE) begin clr = 1'b1; m_st[i] = M_IDLE; end
        end
        if (clr) begin
            m_sz[i] = 0; m_ovf[i] = 1'b0;
        end else begin
            if (r && m_sz[i] > 0) begin
                m_dat[i] = m_q[i][0];
                for (int k = 0; k < 7; k++) m_q[i][k] = m_q[i][k+1];
                m_sz[i]--;
            end
            if (cap) begin
                if (m_sz[i] < 8) begin
                    m_q[i][m_sz[i]] = c; m_sz[i]++;
                end else if (ow) begin
                    for (int k = 0; k < 7; k++) m_q[i][k] = m_q[i][k+1];
                    m_q[i][7] = c;
                    m_ovf[i] = 1'b1;
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [25:0] act(input int i);
        return {ir[i], ce[i], dh[i], lv[i], lf[i], lo[i], lc[i], ld[i]};
    endfunction

    function automatic logic [25:0] exp_m(input int i);
        return {m_st[i] == M_IDLE, (m_st[i] == M_RUN) || (m_st[i] == M_SPLIT),
                m_st[i] == M_SPLIT, m_sz[i] > 0, m_sz[i] == 8, m_ovf[i],
                4'(m_sz[i]), m_dat[i]};
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s inst%0d: got %h, expected %h", nm, i, a, e);
        end
    endtask

    // One clock: drive at negedge, model steps at posedge, compare at next negedge.
    task automatic cycle(input bit t, input bit s, input logic [15:0] c, input bit r);
        trig = t; split = s; count_in = c; lap_rd = r;
        @(posedge clk);
        for (int i = 0; i < N; i++) model_step(i, t, s, c, r);
        @(negedge clk);
        for (int i = 0; i < N; i++) chk("model", i, {6'd0, act(i)}, {6'd0, exp_m(i)});
    endtask

    task automatic pulse(input bit t, input bit s, input logic [15:0] c);
        cycle(t, s, c, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    localparam logic [25:0] RST_PACK = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000};

    initial begin
        bit t, s, r;
        //          t     s     cin       rd    init  ce    dh    cnt   data      valid ovf
        tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 16'h0123, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 16'h0000, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 16'h0150, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 16'h0000, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 16'h0000, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 16'h0123, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 16'h0123, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0200, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0200, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 16'h0300, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 16'h0200, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 16'h0200, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 16'h0400, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 16'h0200, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 16'h0200, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 16'h0999, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 16'h0200, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 16'h0200, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0200, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0200, 1'b0, 1'b0};

        trig = 1'b0; split = 1'b0; lap_rd = 1'b0; count_in = 16'h0000;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) chk("reset_vals", i, {6'd0, act(i)}, {6'd0, RST_PACK});
        reset = 1'b0;

        // Directed vector table (expectations for u0)
        for (int v = 0; v < 18; v++) begin
            cycle(tbl[v].t, tbl[v].s, tbl[v].cin, tbl[v].rd);
            chk($sformatf("tbl%0d", v), 0,
                {9'd0, ir[0], ce[0], dh[0], lc[0], ld[0], lv[0], lo[0]},
                {9'd0, tbl[v].e_init, tbl[v].e_ce, tbl[v].e_dh, tbl[v].e_cnt,
                 tbl[v].e_data, tbl[v].e_valid, tbl[v].e_ovf});
        end

        // Nine captures into an 8-deep buffer, then drain
        pulse(1'b1, 1'b0, 16'h0000);
        for (int i = 1; i <= 9; i++) pulse(1'b0, 1'b1, 16'(16'h1000 + i));
        for (int i = 0; i < 2; i++) begin
            chk("full_cnt", i, {28'd0, lc[i]}, 32'd8);
            chk("full_flag", i, {31'd0, lf[i]}, 32'd1);
            chk("full_ovf", i, {31'd0, lo[i]}, 32'd1);
        end
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 16'h0000, 1'b1);
            chk("drain_drop", 0, {16'd0, ld[0]}, {16'd0, 16'(16'h1001 + k)});
            chk("drain_ow", 1, {16'd0, ld[1]}, {16'd0, 16'(16'h1002 + k)});
        end
        chk("drained_valid", 0, {31'd0, lv[0]}, 32'd0);
        chk("drained_valid", 1, {31'd0, lv[1]}, 32'd0);

        // Pause path clears the sticky overflow
        pulse(1'b1, 1'b0, 16'h0000);
        pulse(1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            chk("clr_init", i, {31'd0, ir[i]}, 32'd1);
            chk("clr_cnt", i, {28'd0, lc[i]}, 32'd0);
            chk("clr_ovf", i, {31'd0, lo[i]}, 32'd0);
        end

        // Full buffer with simultaneous capture and pop
        pulse(1'b1, 1'b0, 16'h0000);
        for (int i = 1; i <= 8; i++) pulse(1'b0, 1'b1, 16'(16'h2000 + i));
        cycle(1'b0, 1'b1, 16'h2999, 1'b1);
        for (int i = 0; i < 2; i++) begin
            chk("fullpop_cnt", i, {28'd0, lc[i]}, 32'd8);
            chk("fullpop_ovf", i, {31'd0, lo[i]}, 32'd0);
            chk("fullpop_data", i, {16'd0, ld[i]}, 32'h0000_2001);
        end
        cycle(1'b0, 1'b0, 16'h0000, 1'b0);

        // Held trig: one event with edge detect, two with level behaviour
        pulse(1'b1, 1'b0, 16'h0000);
        pulse(1'b1, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 16'h0000, 1'b0);
        cycle(1'b1, 1'b0, 16'h0000, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("held_level_ce", 2, {31'd0, ce[2]}, 32'd1);
        chk("held_level_init", 2, {31'd0, ir[2]}, 32'd0);
        chk("held_edge_ce", 0, {31'd0, ce[0]}, 32'd0);
        pulse(1'b1, 1'b0, 16'h0000);

        // Asynchronous reset in the middle of RUN
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < N; i++) chk("async_reset", i, {6'd0, act(i)}, {6'd0, RST_PACK});
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Randomised stimulus against the model
        for (int n = 0; n < 3000; n++) begin
            if (n < 1000) begin
                t = ($urandom_range(0, 31) == 0);
                r = ($urandom_range(0, 15) == 0);
            end else if (n < 2000) begin
                t = ($urandom_range(0, 7) == 0);
                r = ($urandom_range(0, 2) == 0);
            end else begin
                t = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 1) == 0);
            end
            s = ($urandom_range(0, 3) == 0);
            cycle(t, s, 16'($urandom), r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ctl_lap.md
# ctl_lap

Parametrised stopwatch control unit with lap memory, the next generation of the stopwatch `Ctl` FSM. It sequences the counter datapath through idle, running, split-frozen and paused states from the `trig` and `split` buttons. On every split event while counting it captures a snapshot of the running count into a circular lap buffer that the display/readout logic drains one entry at a time. It sits between the debounced button inputs and the counter/display datapath.

## Interface
- CNT_W, 16: width of the count snapshot captured per lap.
- DEPTH, 8: number of lap entries; power of two, at least 2.
- EDGE_DET, 1: 1 = act on rising edges of `trig`/`split`; 0 = act on every cycle the input is sampled high (legacy level behaviour).
- OVERWRITE, 0: 1 = a write to a full buffer overwrites the oldest entry; 0 = the write is dropped.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- trig  in  1  start/stop button, already debounced.
- split  in  1  split/lap/clear button, already debounced.
- count_in  in  CNT_W  current counter value, sampled on lap capture.
- lap_rd  in  1  pop request, one cycle per entry.
- init_regs  out  1  clear the counter registers; high only in IDLE.
- count_enabled  out  1  counter runs; high in RUN and SPLIT.
- display_hold  out  1  display frozen; high only in SPLIT.
- lap_data  out  CNT_W  last popped entry; registered.
- lap_valid  out  1  buffer not empty.
- lap_full  out  1  buffer holds DEPTH entries.
- lap_count  out  $clog2(DEPTH+1)  number of stored entries.
- lap_ovf  out  1  sticky flag: at least one lap was dropped (OVERWRITE=0) or overwritten (OVERWRITE=1).

## Operation
- Event detection:
  - With EDGE_DET=1: `t_ev = trig & ~trig_q` and `s_ev = split & ~split_q`. `trig_q` and `split_q` reset to 0, so an input already high when reset releases counts as an edge.
  - With EDGE_DET=0: `t_ev = trig` and `s_ev = split`.
- Priority: when `t_ev` and `s_ev` occur in the same cycle, `t_ev` wins and `s_ev` is ignored. No capture happens.
- States: IDLE, RUN, SPLIT, PAUSE. Reset enters IDLE.
  - IDLE: `t_ev` goes to RUN. `s_ev` is ignored.
  - RUN: `t_ev` goes to PAUSE. `s_ev` goes to SPLIT and captures a lap.
  - SPLIT: `t_ev` goes to PAUSE and the display is released. `s_ev` goes to RUN and captures a lap.
  - PAUSE: `t_ev` goes to RUN. `s_ev` goes to IDLE and clears the lap buffer.
- Outputs are Moore, decoded from a registered state:

  | State | init_regs | count_enabled | display_hold |
  |---|---|---|---|
  | IDLE | 1 | 0 | 0 |
  | RUN | 0 | 1 | 0 |
  | SPLIT | 0 | 1 | 1 |
  | PAUSE | 0 | 0 | 0 |

- Lap capture: writes `count_in`, as sampled in the event cycle, at the write pointer.
- Buffer: circular, with write pointer, read pointer and occupancy counter; the pointers wrap modulo DEPTH.
- Full buffer with OVERWRITE=0: the write is dropped, `lap_ovf` is set, and the contents and pointers are unchanged.
- Full buffer with OVERWRITE=1: the oldest entry is replaced, both pointers advance, `lap_count` stays at DEPTH, and `lap_ovf` is set.
- Pop: `lap_rd` with `lap_valid` loads the head entry into `lap_data`, advances the read pointer and decrements `lap_count`.
- Pop on empty: ignored; `lap_data` holds its value.
- Simultaneous capture and pop:
  - Buffer not full: both take effect and `lap_count` is unchanged.
  - Buffer full: the pop frees a slot, so the write succeeds without overflow in either OVERWRITE mode.
  - Buffer empty: only the capture takes effect; the pop is ignored and `lap_data` keeps its old value.
- Clear (PAUSE to IDLE): pointers and `lap_count` go to 0 and `lap_ovf` goes to 0. `lap_data` is not cleared. A `lap_rd` in the clear cycle is ignored.

## Timing
- Reset values: state IDLE; `init_regs`=1; `count_enabled`=0; `display_hold`=0; `lap_data`=0; `lap_valid`=0; `lap_full`=0; `lap_count`=0; `lap_ovf`=0.
- State outputs change on the first rising edge at which the event is sampled. They are visible one cycle after the input rises.
- Capture: `lap_count`, `lap_valid`, `lap_full` and `lap_ovf` update on the same edge as the state change.
- Pop: `lap_data` updates on the edge that samples `lap_rd`, with a latency of one cycle.
- EDGE_DET=1: a button held for N cycles produces exactly one event.
- EDGE_DET=0: a button held for N cycles produces N events, one per cycle. For example, `trig` held 2 cycles in RUN goes RUN, then PAUSE, then RUN.
- Mid-operation reset: every output returns to its reset value asynchronously; buffer contents become don't-care.

## Test plan
- Reset, then release: `init_regs`=1, `count_enabled`=0 and `lap_count`=0. Then one `trig` pulse: RUN, so `init_regs`=0 and `count_enabled`=1.
- RUN with `count_in`=0x0123: `split` gives `display_hold`=1 and `lap_count`=1. A second `split` with 0x0200 gives `display_hold`=0 and `lap_count`=2. Two `lap_rd` pulses give `lap_data` 0x0123 then 0x0200, and `lap_valid`=0 afterwards.
- With DEPTH=8, OVERWRITE=0: 9 captures give `lap_full`=1, `lap_ovf`=1 and `lap_count`=8; popping all entries returns laps 1–8. Repeat with OVERWRITE=1: popping returns laps 2–9.
- Pause path: `trig` in RUN, then `split` in PAUSE: IDLE, `init_regs`=1, `lap_count`=0, `lap_ovf`=0.
- `trig` and `split` asserted in the same cycle in RUN: PAUSE, no capture, `lap_count` unchanged. With EDGE_DET=0, `trig` held 2 cycles in RUN: ends in RUN.
- Capture and `lap_rd` in the same cycle with `lap_count`=8 (full): `lap_count` stays 8, no overflow, and the popped entry is the oldest. Also assert `reset` mid-RUN: all outputs go to their reset values immediately.
